// File: rtl/explored_scan_if.sv
// explored_scan_if: request/result bundle between the A* control FSM and the
// explored-node search engine. The RAM read port stays as plain module ports.
//
// Handshake: the requester raises start for one cycle together with key_sel,
// query_key and entries. The engine accepts it only while idle (busy=0 and
// done=0). A start seen while busy or during the done cycle is dropped, not
// queued. Completion is the single-cycle done pulse. hit, hit_index and
// hit_record are valid from done onwards and hold until the next accepted start.
interface explored_scan_if #(
    parameter int ADDR_W = 7,
    parameter int REC_W  = 272,
    parameter int KEY_W  = 16
);
    logic              start;
    logic              key_sel;
    logic [KEY_W-1:0]  query_key;
    logic [ADDR_W:0]   entries;
    logic              busy;
    logic              done;
    logic              hit;
    logic [ADDR_W:0]   hit_index;
    logic [REC_W-1:0]  hit_record;

    modport master (
        output start, key_sel, query_key, entries,
        input  busy, done, hit, hit_index, hit_record
    );

    modport slave (
        input  start, key_sel, query_key, entries,
        output busy, done, hit, hit_index, hit_record
    );
endinterface

// File: rtl/explored_scan.sv
// explored_scan: pipelined linear search over the explored-node RAM, one entry
// per clock. It returns the lowest matching address and its record. On a miss
// it returns the first free slot instead.
// Optional build macro: EXPLORED_SCAN_SENTINEL_EN. When it is defined, a
// compared entry whose selected key is zero (and does not match) ends the scan
// as a miss at that address.
module explored_scan #(
    parameter int DEPTH    = 128,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int REC_W    = 272,
    parameter int KEY_W    = 16,
    parameter int KEY0_LSB = 224,
    parameter int KEY1_LSB = 208
) (
    input  logic              clk,
    input  logic              reset,
    explored_scan_if.slave    bus,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [REC_W-1:0]  rd_data,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Address arithmetic is ADDR_W+1 wide so that entries == DEPTH does not wrap.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t              state_q;
    state_t              state_d;

    logic                key_sel_q;
    logic [KEY_W-1:0]    query_q;
    logic [ADDR_W:0]     entries_q;

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic                cmp_valid_q;

    logic                hit_q;
    logic [ADDR_W:0]     hit_index_q;
    logic [REC_W-1:0]    hit_record_q;

    logic [ADDR_W:0]     entries_clamped;
    logic [ADDR_W:0]     last_addr;
    logic                last_issue;
    logic [KEY_W-1:0]    sel_key;
    logic                compare_active;
    logic                match;
    logic                sentinel;

    // Clamp the requested length and evaluate the compare stage on the returning read data.
    always_comb begin
        entries_clamped = (bus.entries > DEPTH_W) ? DEPTH_W : bus.entries;
        last_addr       = entries_q - (ADDR_W+1)'(1);
        last_issue      = ({1'b0, addr_q} == last_addr);
        sel_key         = key_sel_q ? rd_data[KEY1_LSB +: KEY_W]
                                    : rd_data[KEY0_LSB +: KEY_W];
        // The first SCAN cycle has no data back yet, so cmp_valid_q gates it.
        compare_active  = cmp_valid_q && ((state_q == S_SCAN) || (state_q == S_DRAIN));
        match           = compare_active && (sel_key == query_q);
`ifdef EXPLORED_SCAN_SENTINEL_EN
        sentinel        = compare_active && !match && (sel_key == '0);
`else
        sentinel        = 1'b0;
`endif
    end

    // Next-state logic: a hit or sentinel ends the scan at once, before the address range is exhausted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (entries_clamped == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (match || sentinel) begin
                    state_d = S_DONE;
                end else if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any scan in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch arguments, step the read address, pipeline the compare and capture the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_sel_q    <= 1'b0;
            query_q      <= '0;
            entries_q    <= '0;
            addr_q       <= '0;
            cmp_addr_q   <= '0;
            cmp_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            hit_index_q  <= '0;
            hit_record_q <= '0;
        end else begin
            // The compare stage always looks at the address issued one cycle earlier.
            cmp_valid_q <= (state_q == S_SCAN);
            cmp_addr_q  <= addr_q;

            // Increment only while scanning. Hold the last address through DRAIN, otherwise park at 0.
            if ((state_q == S_SCAN) && (state_d == S_SCAN)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end else if (state_d != S_DRAIN) begin
                addr_q <= '0;
            end

            // Preload the miss result on accept, so that a scan running off the end needs no extra update.
            if ((state_q == S_IDLE) && bus.start) begin
                key_sel_q    <= bus.key_sel;
                query_q      <= bus.query_key;
                entries_q    <= entries_clamped;
                hit_q        <= 1'b0;
                hit_index_q  <= entries_clamped;
                hit_record_q <= '0;
            end

            if (match) begin
                hit_q        <= 1'b1;
                hit_index_q  <= {1'b0, cmp_addr_q};
                hit_record_q <= rd_data;
            end else if (sentinel) begin
                hit_index_q  <= {1'b0, cmp_addr_q};
            end
        end
    end

    assign rd_addr        = addr_q;
    assign state_dbg      = state_q;
    assign bus.busy       = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.hit        = hit_q;
    assign bus.hit_index  = hit_index_q;
    assign bus.hit_record = hit_record_q;

endmodule

// File: tb/tb_explored_scan.sv
// tb_explored_scan: directed and randomized checks of explored_scan against a
// search model that works directly on the bench's copy of the RAM contents.
module tb_explored_scan;

    localparam int DEPTH    = 128;
    localparam int ADDR_W   = 7;
    localparam int REC_W    = 272;
    localparam int KEY_W    = 16;
    localparam int KEY0_LSB = 224;
    localparam int KEY1_LSB = 208;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [REC_W-1:0]  rd_data;
    logic [1:0]        state_dbg;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    explored_scan_if #(.ADDR_W(ADDR_W), .REC_W(REC_W), .KEY_W(KEY_W)) bus ();

    explored_scan #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REC_W(REC_W), .KEY_W(KEY_W),
        .KEY0_LSB(KEY0_LSB), .KEY1_LSB(KEY1_LSB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .state_dbg(state_dbg)
    );

    // Clock and a one-cycle-latency RAM read port.
    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= mem[rd_addr];

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k;
        do k = KEY_W'($urandom_range(16'h0100, 16'hFFFF)); while (k == 16'h7777);
        return k;
    endfunction

    function automatic logic [KEY_W-1:0] key_of(input int idx, input logic ks);
        logic [REC_W-1:0] r;
        r = mem[idx];
        return ks ? r[KEY1_LSB +: KEY_W] : r[KEY0_LSB +: KEY_W];
    endfunction

    // Random records with nonzero keys >= 0x100 and never 0x7777.
    task automatic fill_random();
        logic [REC_W-1:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r = '0;
            for (int w = 0; w < 9; w++) r = {r[REC_W-33:0], $urandom};
            r[KEY0_LSB +: KEY_W] = rand_key();
            r[KEY1_LSB +: KEY_W] = rand_key();
            mem[i] = r;
        end
    endtask

    // Reference: first entry below min(n, DEPTH) whose key equals q. The sentinel build also stops at a zero key.
    task automatic model(input logic ks, input logic [KEY_W-1:0] q, input logic [ADDR_W:0] n,
                         output logic e_hit, output logic [ADDR_W:0] e_idx,
                         output logic [REC_W-1:0] e_rec, output int e_cyc);
        int lim;
        logic [KEY_W-1:0] k;
        lim   = (int'(n) > DEPTH) ? DEPTH : int'(n);
        e_hit = 1'b0;
        e_idx = (ADDR_W+1)'(lim);
        e_rec = '0;
        e_cyc = (lim == 0) ? 1 : lim + 2;
        for (int i = 0; i < lim; i++) begin
            k = key_of(i, ks);
            if (k == q) begin
                e_hit = 1'b1; e_idx = (ADDR_W+1)'(i); e_rec = mem[i]; e_cyc = i + 3;
                break;
            end
`ifdef EXPLORED_SCAN_SENTINEL_EN
            if (k == '0) begin
                e_idx = (ADDR_W+1)'(i); e_cyc = i + 3;
                break;
            end
`endif
        end
    endtask

    // Driver: issue one request, then watch `budget` cycles counted from the accepting edge.
    task automatic drive_scan(input logic ks, input logic [KEY_W-1:0] q, input logic [ADDR_W:0] n,
                              input int budget, output int got_cyc, output int dones,
                              output int peak, output bit range_ok, output logic busy_at_done);
        int lim;
        lim = (int'(n) > DEPTH) ? DEPTH : int'(n);
        @(negedge clk);
        bus.start = 1'b1; bus.key_sel = ks; bus.query_key = q; bus.entries = n;
        @(posedge clk); #1;
        // Scramble the arguments so that a design which fails to latch them misbehaves.
        bus.start = 1'b0;
        bus.key_sel = 1'($urandom_range(0, 1));
        bus.query_key = KEY_W'($urandom);
        bus.entries = (ADDR_W+1)'($urandom);
        got_cyc = 0; dones = 0; peak = -1; range_ok = 1'b1; busy_at_done = 1'bx;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (bus.busy === 1'b1) begin
                if (int'(rd_addr) > peak) peak = int'(rd_addr);
                if (int'(rd_addr) >= lim) range_ok = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dones++;
                if (got_cyc == 0) begin got_cyc = cyc; busy_at_done = bus.busy; end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.key_sel = 1'b0; bus.query_key = '0; bus.entries = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL reset hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== '0) $display("FAIL reset hit_index: got %0d want 0", bus.hit_index); else n_pass++;
        n_total++; if (bus.hit_record !== '0) $display("FAIL reset hit_record: got %h want 0", bus.hit_record); else n_pass++;
        n_total++; if (rd_addr !== '0) $display("FAIL reset rd_addr: got %0d want 0", rd_addr); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_hit_mid();
        int got, dn, pk; bit rok; logic bad;
        fill_random();
        mem[6][KEY0_LSB +: KEY_W] = 16'h0042;
        drive_scan(1'b0, 16'h0042, 8'd10, 13, got, dn, pk, rok, bad);
        n_total++; if (got != 9) $display("FAIL hit_mid done_cycle: got %0d want 9", got); else n_pass++;
        n_total++; if (dn != 1) $display("FAIL hit_mid done_pulses: got %0d want 1", dn); else n_pass++;
        n_total++; if (bad !== 1'b0) $display("FAIL hit_mid busy_at_done: got %b want 0", bad); else n_pass++;
        n_total++; if (bus.hit !== 1'b1) $display("FAIL hit_mid hit: got %b want 1", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd6) $display("FAIL hit_mid hit_index: got %0d want 6", bus.hit_index); else n_pass++;
        n_total++; if (bus.hit_record !== mem[6]) $display("FAIL hit_mid hit_record: got %h want %h", bus.hit_record, mem[6]); else n_pass++;
    endtask

    task automatic test_miss_full();
        int got, dn, pk; bit rok; logic bad;
        fill_random();
        drive_scan(1'b0, 16'h7777, 8'd128, 134, got, dn, pk, rok, bad);
        n_total++; if (got != 130) $display("FAIL miss_full done_cycle: got %0d want 130", got); else n_pass++;
        n_total++; if (dn != 1) $display("FAIL miss_full done_pulses: got %0d want 1", dn); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL miss_full hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd128) $display("FAIL miss_full hit_index: got %0d want 128", bus.hit_index); else n_pass++;
        n_total++; if (bus.hit_record !== '0) $display("FAIL miss_full hit_record: got %h want 0", bus.hit_record); else n_pass++;
        n_total++; if (pk != 127) $display("FAIL miss_full rd_addr_peak: got %0d want 127", pk); else n_pass++;
        n_total++; if (rok !== 1'b1) $display("FAIL miss_full rd_addr_range: got %b want 1", rok); else n_pass++;
    endtask

    task automatic test_key_sel();
        int got, dn, pk; bit rok; logic bad;
        fill_random();
        mem[3][KEY1_LSB +: KEY_W] = 16'h0005;
        mem[8][KEY1_LSB +: KEY_W] = 16'h0005;
        drive_scan(1'b1, 16'h0005, 8'd12, 10, got, dn, pk, rok, bad);
        n_total++; if (got != 6) $display("FAIL key_sel1 done_cycle: got %0d want 6", got); else n_pass++;
        n_total++; if (bus.hit !== 1'b1) $display("FAIL key_sel1 hit: got %b want 1", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd3) $display("FAIL key_sel1 hit_index: got %0d want 3", bus.hit_index); else n_pass++;
        n_total++; if (bus.hit_record !== mem[3]) $display("FAIL key_sel1 hit_record: got %h want %h", bus.hit_record, mem[3]); else n_pass++;
        drive_scan(1'b0, 16'h0005, 8'd12, 18, got, dn, pk, rok, bad);
        n_total++; if (got != 14) $display("FAIL key_sel0 done_cycle: got %0d want 14", got); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL key_sel0 hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd12) $display("FAIL key_sel0 hit_index: got %0d want 12", bus.hit_index); else n_pass++;
    endtask

    task automatic test_empty();
        int got, dn, pk; bit rok; logic bad;
        fill_random();
        drive_scan(1'b0, key_of(0, 1'b0), 8'd0, 5, got, dn, pk, rok, bad);
        n_total++; if (got != 1) $display("FAIL empty done_cycle: got %0d want 1", got); else n_pass++;
        n_total++; if (dn != 1) $display("FAIL empty done_pulses: got %0d want 1", dn); else n_pass++;
        n_total++; if (bad !== 1'b0) $display("FAIL empty busy_at_done: got %b want 0", bad); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL empty hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd0) $display("FAIL empty hit_index: got %0d want 0", bus.hit_index); else n_pass++;
        n_total++; if (bus.hit_record !== '0) $display("FAIL empty hit_record: got %h want 0", bus.hit_record); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int got, dn;
        fill_random();
        got = 0; dn = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_sel = 1'b0; bus.query_key = 16'h7777; bus.entries = 8'd30;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            // A second request that would hit early, raised while the first scan is running.
            if (cyc == 5) begin
                bus.start = 1'b1; bus.query_key = key_of(2, 1'b0); bus.entries = 8'd3;
            end else if (cyc == 6) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dn++;
                if (got == 0) got = cyc;
            end
            @(posedge clk); #1;
        end
        n_total++; if (got != 32) $display("FAIL ignored_start done_cycle: got %0d want 32", got); else n_pass++;
        n_total++; if (dn != 1) $display("FAIL ignored_start done_pulses: got %0d want 1", dn); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL ignored_start hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== 8'd30) $display("FAIL ignored_start hit_index: got %0d want 30", bus.hit_index); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int got, dn, pk, e_cyc; bit rok; logic bad, e_hit;
        logic [ADDR_W:0] e_idx; logic [REC_W-1:0] e_rec; logic [KEY_W-1:0] q;
        fill_random();
        @(negedge clk);
        bus.start = 1'b1; bus.key_sel = 1'b0; bus.query_key = 16'h7777; bus.entries = 8'd50;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL abort busy_before: got %b want 1", bus.busy); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL abort busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL abort done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.hit_index !== '0) $display("FAIL abort hit_index: got %0d want 0", bus.hit_index); else n_pass++;
        n_total++; if (rd_addr !== '0) $display("FAIL abort rd_addr: got %0d want 0", rd_addr); else n_pass++;
        n_total++; if (bus.hit_record !== '0) $display("FAIL abort hit_record: got %h want 0", bus.hit_record); else n_pass++;
        reset = 1'b1;
        dn = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (bus.done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        n_total++; if (dn != 0) $display("FAIL abort stray_done: got %0d want 0", dn); else n_pass++;
        q = key_of(17, 1'b1);
        model(1'b1, q, 8'd50, e_hit, e_idx, e_rec, e_cyc);
        drive_scan(1'b1, q, 8'd50, e_cyc + 4, got, dn, pk, rok, bad);
        n_total++; if (got != e_cyc) $display("FAIL abort_restart done_cycle: got %0d want %0d", got, e_cyc); else n_pass++;
        n_total++; if (bus.hit_index !== e_idx) $display("FAIL abort_restart hit_index: got %0d want %0d", bus.hit_index, e_idx); else n_pass++;
        n_total++; if (bus.hit_record !== e_rec) $display("FAIL abort_restart hit_record: got %h want %h", bus.hit_record, e_rec); else n_pass++;
    endtask

    task automatic test_sentinel();
        int got, dn, pk, want_cyc; bit rok; logic bad;
        logic [ADDR_W:0] want_idx;
        fill_random();
        mem[4][KEY0_LSB +: KEY_W] = 16'h0000;
`ifdef EXPLORED_SCAN_SENTINEL_EN
        want_cyc = 7;  want_idx = 8'd4;
`else
        want_cyc = 22; want_idx = 8'd20;
`endif
        drive_scan(1'b0, 16'h7777, 8'd20, 26, got, dn, pk, rok, bad);
        n_total++; if (got != want_cyc) $display("FAIL sentinel done_cycle: got %0d want %0d", got, want_cyc); else n_pass++;
        n_total++; if (dn != 1) $display("FAIL sentinel done_pulses: got %0d want 1", dn); else n_pass++;
        n_total++; if (bus.hit !== 1'b0) $display("FAIL sentinel hit: got %b want 0", bus.hit); else n_pass++;
        n_total++; if (bus.hit_index !== want_idx) $display("FAIL sentinel hit_index: got %0d want %0d", bus.hit_index, want_idx); else n_pass++;
    endtask

    task automatic test_random();
        int got, dn, pk, e_cyc; bit rok; logic bad, e_hit, ks;
        logic [ADDR_W:0] e_idx, n, exp_idx; logic [REC_W-1:0] e_rec; logic [KEY_W-1:0] q;
        fill_random();
        for (int z = 0; z < 6; z++) mem[$urandom_range(0, DEPTH-1)][KEY0_LSB +: KEY_W] = '0;
        for (int t = 0; t < 24; t++) begin
            ks = 1'($urandom_range(0, 1));
            n  = (ADDR_W+1)'($urandom_range(0, DEPTH + 20));
            q  = ($urandom_range(0, 3) != 0) ? key_of($urandom_range(0, DEPTH-1), ks) : 16'h7777;
            model(ks, q, n, e_hit, e_idx, e_rec, e_cyc);
            exp_q.push_back(e_idx);
            drive_scan(ks, q, n, e_cyc + 4, got, dn, pk, rok, bad);
            exp_idx = exp_q.pop_front();
            n_total++; if (got != e_cyc) $display("FAIL rand[%0d] done_cycle: got %0d want %0d", t, got, e_cyc); else n_pass++;
            n_total++; if (dn != 1) $display("FAIL rand[%0d] done_pulses: got %0d want 1", t, dn); else n_pass++;
            n_total++; if (bus.hit !== e_hit) $display("FAIL rand[%0d] hit: got %b want %b", t, bus.hit, e_hit); else n_pass++;
            n_total++; if (bus.hit_index !== exp_idx) $display("FAIL rand[%0d] hit_index: got %0d want %0d", t, bus.hit_index, exp_idx); else n_pass++;
            n_total++; if (bus.hit_record !== e_rec) $display("FAIL rand[%0d] hit_record: got %h want %h", t, bus.hit_record, e_rec); else n_pass++;
            n_total++; if (rok !== 1'b1) $display("FAIL rand[%0d] rd_addr_range: got %b want 1", t, rok); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc, got1, got2, c1, c2; logic h1, h2;
        logic [ADDR_W:0] i1, i2; logic [REC_W-1:0] r1, r2; logic [KEY_W-1:0] q1, q2;
        fill_random();
        q1 = key_of(10, 1'b1);
        q2 = key_of(20, 1'b0);
        model(1'b1, q1, 8'd40, h1, i1, r1, c1);
        model(1'b0, q2, 8'd64, h2, i2, r2, c2);
        @(negedge clk);
        bus.start = 1'b1; bus.key_sel = 1'b1; bus.query_key = q1; bus.entries = 8'd40;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= c1 + 4 && bus.done !== 1'b1) begin
            @(posedge clk); #1; cyc++;
        end
        got1 = (bus.done === 1'b1) ? cyc : 0;
        n_total++; if (got1 != c1) $display("FAIL b2b first done_cycle: got %0d want %0d", got1, c1); else n_pass++;
        n_total++; if (bus.hit_index !== i1) $display("FAIL b2b first hit_index: got %0d want %0d", bus.hit_index, i1); else n_pass++;
        // Raise the next request during the done cycle and keep it up; it only takes once idle.
        bus.start = 1'b1; bus.key_sel = 1'b0; bus.query_key = q2; bus.entries = 8'd64;
        @(posedge clk); #1;
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL b2b idle_gap: got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b second_accept busy: got %b want 1", bus.busy); else n_pass++;
        cyc = 1;
        while (cyc <= c2 + 4 && bus.done !== 1'b1) begin
            @(posedge clk); #1; cyc++;
        end
        got2 = (bus.done === 1'b1) ? cyc : 0;
        n_total++; if (got2 != c2) $display("FAIL b2b second done_cycle: got %0d want %0d", got2, c2); else n_pass++;
        n_total++; if (bus.hit !== h2) $display("FAIL b2b second hit: got %b want %b", bus.hit, h2); else n_pass++;
        n_total++; if (bus.hit_index !== i2) $display("FAIL b2b second hit_index: got %0d want %0d", bus.hit_index, i2); else n_pass++;
        n_total++; if (bus.hit_record !== r2) $display("FAIL b2b second hit_record: got %h want %h", bus.hit_record, r2); else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.key_sel = 1'b0; bus.query_key = '0; bus.entries = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_hit_mid();
        test_miss_full();
        test_key_sel();
        test_empty();
        test_ignored_start();
        test_reset_abort();
        test_sentinel();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
